// File: rtl/efi_pkg.sv
// Shared EFI definitions: wheel geometry,
// counter widths and crank decoder states.
package efi_pkg;

  localparam int TEETH_PER_REV = 58;
  localparam int MISSING_TEETH = 2;
  localparam int PERIOD_W = 24;
  localparam int TOOTH_IDX_W = 6;

  typedef enum logic [1:0] {
    IDLE,
    HUNT,
    SYNCED
  } crank_state_t;

endpackage

// File: rtl/vr_edge_sync.sv
// Two-flop synchroniser for the VR input
// followed by a registered rising-edge pulse.
module vr_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
      rise <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
      rise <= s2 & ~s3;
    end
  end

endmodule

// File: rtl/crank_wheel_decoder.sv
// Missing-tooth crank decoder: gap search,
// tooth indexing, period and stall tracking.
module crank_wheel_decoder
  import efi_pkg::*;
#(
  parameter int TEETH = TEETH_PER_REV,
  parameter int CNT_W = PERIOD_W,
  parameter int MIN_PERIOD = 40,
  parameter int TIMEOUT = 2000000
) (
  input  logic clk_efi,
  input  logic rst,
  input  logic vrin,
  output logic tooth_strobe,
  output logic [TOOTH_IDX_W-1:0] tooth_idx,
  output logic [CNT_W-1:0] tooth_period,
  output logic synced,
  output logic [7:0] sync_loss_cnt
);

  localparam logic [CNT_W-1:0] MIN_V =
    CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] TO_V =
    CNT_W'(TIMEOUT);
  localparam logic [TOOTH_IDX_W-1:0] LAST =
    TOOTH_IDX_W'(TEETH - 1);

  logic rise;

  vr_edge_sync u_sync (
    .clk (clk_efi),
    .rst (rst),
    .din (vrin),
    .rise(rise)
  );

  crank_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, prev_q;
  logic prev_valid_q;
  logic [CNT_W:0] thresh;
  logic stall, accept, gap, at_last;
  logic store, loss, bump_loss;
  logic [TOOTH_IDX_W-1:0] idx_d;
  logic synced_d;

  // 1.5x threshold held one bit wider so it cannot wrap
  always_comb begin
    thresh = {1'b0, prev_q}
           + {2'b00, prev_q[CNT_W-1:1]};
    stall = (cnt_q == TO_V);
    accept = rise && (cnt_q >= MIN_V) && !stall;
    gap = prev_valid_q && ({1'b0, cnt_q} > thresh);
    at_last = (tooth_idx == LAST);
  end

  always_ff @(posedge clk_efi or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (accept) state_d = HUNT;
      HUNT:
        if (accept && gap) state_d = SYNCED;
      SYNCED:
        if (accept && (gap != at_last))
          state_d = HUNT;
      default: state_d = IDLE;
    endcase
    if (stall) state_d = IDLE;
  end

  always_comb begin
    store = accept && (state_q != IDLE) && !gap;
    loss = accept && (state_q == SYNCED)
        && (gap != at_last);
    bump_loss = loss
             || (stall && (state_q == SYNCED));
    idx_d = tooth_idx;
    synced_d = synced;
    unique case (1'b1)
      stall, loss: begin
        idx_d = '0;
        synced_d = 1'b0;
      end
      accept && (state_q == HUNT) && gap: begin
        idx_d = '0;
        synced_d = 1'b1;
      end
      accept && (state_q == SYNCED) && !loss:
        idx_d = gap ? '0 : tooth_idx + 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_efi or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      prev_q <= '0;
      prev_valid_q <= 1'b0;
      tooth_strobe <= 1'b0;
      tooth_idx <= '0;
      tooth_period <= '0;
      synced <= 1'b0;
      sync_loss_cnt <= '0;
    end else begin
      tooth_strobe <= accept;
      tooth_idx <= idx_d;
      synced <= synced_d;
      if (accept)
        cnt_q <= CNT_W'(1);
      else if (cnt_q != '1)
        cnt_q <= cnt_q + 1'b1;
      if (stall) begin
        prev_valid_q <= 1'b0;
        tooth_period <= '0;
      end else if (store) begin
        prev_q <= cnt_q;
        tooth_period <= cnt_q;
        prev_valid_q <= 1'b1;
      end
      if (bump_loss && (sync_loss_cnt != 8'hFF))
        sync_loss_cnt <= sync_loss_cnt + 1'b1;
    end
  end

endmodule
